// File: rtl/checksum_fold.sv
`default_nettype none
// ============================================================================
// Module  : checksum_fold
// Brief   : Folds frames of FRAME_LEN 12-bit products into a 16-bit ones'-
//           complement checksum behind a single-entry valid/ready slot.
// Revision: 1.0  initial release
// ============================================================================
module checksum_fold #(
  parameter int FRAME_LEN = 15,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_data_vld,
  input  logic [11:0]      in_data,
  input  logic             flush,
  input  logic             out_rdy,
  output logic             out_vld,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_vld;
  logic [15:0]      r_out_data;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_overrun;

  logic [16:0]      w_sum;
  logic [15:0]      w_fold;
  logic             w_accept;
  logic             w_last;
  logic             w_slot_free;
  logic             w_load;

  // One end-around carry suffices: a 12-bit addend can never wrap twice.
  assign w_sum       = {1'b0, r_acc} + {5'b0, in_data};
  assign w_fold      = w_sum[15:0] + {15'b0, w_sum[16]};
  assign w_accept    = in_data_vld & ~flush;
  assign w_last      = w_accept & (r_cnt == c_LAST);
  assign w_slot_free = ~r_out_vld | out_rdy;
  assign w_load      = w_last & w_slot_free;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_fold;
        r_cnt <= r_cnt + c_ONE;
      end
    end
  end

  // Output slot; a load in the same cycle as a drain simply replaces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_frame_cnt <= '0;
    end else if (w_load) begin
      r_out_vld   <= 1'b1;
      r_out_data  <= ~w_fold;
      r_frame_cnt <= r_frame_cnt + c_ONE;
    end else if (r_out_vld && out_rdy) begin
      r_out_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (flush) begin
      r_overrun <= 1'b0;
    end else if (w_last && !w_slot_free) begin
      r_overrun <= 1'b1;
    end
  end

  assign out_vld   = r_out_vld;
  assign out_data  = r_out_data;
  assign frame_cnt = r_frame_cnt;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_checksum_fold.sv
`default_nettype none
// ============================================================================
// Module  : tb_checksum_fold
// Brief   : Self-checking bench: vector table, corner sequences, random model.
// Revision: 1.0  initial release
// ============================================================================
module tb_checksum_fold;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_vld, flush, rdy;
  logic [11:0] in_data;
  logic        out_vld, overrun;
  logic [15:0] out_data;
  logic [7:0]  frame_cnt;

  logic        in32_vld, flush32, rdy32;
  logic [11:0] in32_data;
  logic        vld32, ovr32;
  logic [15:0] data32;
  logic [7:0]  fc32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  checksum_fold #(.FRAME_LEN(15), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_data_vld(in_vld), .in_data(in_data),
    .flush(flush), .out_rdy(rdy), .out_vld(out_vld), .out_data(out_data),
    .frame_cnt(frame_cnt), .overrun(overrun)
  );

  checksum_fold #(.FRAME_LEN(32), .CNT_W(8)) dut32 (
    .clk(clk), .reset(reset), .in_data_vld(in32_vld), .in_data(in32_data),
    .flush(flush32), .out_rdy(rdy32), .out_vld(vld32), .out_data(data32),
    .frame_cnt(fc32), .overrun(ovr32)
  );

  typedef struct {
    bit          ramp;
    logic [11:0] mult;
    int          gap;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic v, input logic [11:0] d);
    in_vld  = v;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_const(input logic [11:0] d, input int n);
    for (int j = 0; j < n; j++) send(1'b1, d);
    in_vld = 1'b0;
  endtask

  // Ones'-complement of the total, folded as a whole number.
  function automatic logic [15:0] ocsum(input int unsigned s);
    int unsigned t;
    t = s;
    while ((t >> 16) != 0) t = (t & 32'hFFFF) + (t >> 16);
    return ~t[15:0];
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned m_sum;
    int          m_n;
    logic        m_vld, m_ovr, m_done, m_free, acc_s;
    logic [15:0] m_data, m_res;
    logic [7:0]  m_fc;
    logic [11:0] v;

    vecs[0] = '{1'b1, 12'd1,    10, 16'hFF96};
    vecs[1] = '{1'b1, 12'd255,  0,  16'h9768};
    vecs[2] = '{1'b1, 12'd7,    2,  16'hFD20};
    vecs[3] = '{1'b0, 12'hFFF,  0,  16'h100E};
    vecs[4] = '{1'b0, 12'd0,    1,  16'hFFFF};

    reset = 1'b0; in_vld = 0; in_data = 0; flush = 0; rdy = 1;
    in32_vld = 0; in32_data = 0; flush32 = 0; rdy32 = 1;
    #12;
    chk("reset_state", {out_vld, overrun, out_data, frame_cnt}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 15; j++) begin
        v = vecs[k].ramp ? 12'(j * int'(vecs[k].mult)) : vecs[k].mult;
        send(1'b1, v);
        if (j < 14) repeat (vecs[k].gap) send(1'b0, 12'h0);
      end
      chk("vec_vld", {31'b0, out_vld}, 32'h1);
      chk("vec_data", {16'h0, out_data}, {16'h0, vecs[k].exp});
      chk("vec_fcnt", {24'h0, frame_cnt}, 32'(k + 1));
      send(1'b0, 12'h0);
      chk("vec_drain", {31'b0, out_vld}, 32'h0);
    end

    // Overrun: two frames into a slot that is never drained.
    do_reset();
    rdy = 1'b0;
    frame_const(12'h001, 15);
    chk("ovr_first", {out_vld, overrun, out_data, 8'h0}, {1'b1, 1'b0, 16'hFFF0, 8'h0});
    frame_const(12'h001, 15);
    chk("ovr_set", {out_vld, overrun, out_data, frame_cnt}, {1'b1, 1'b1, 16'hFFF0, 8'd1});
    rdy = 1'b1;
    send(1'b0, 12'h0);
    chk("ovr_drain", {31'b0, out_vld}, 32'h0);
    chk("ovr_sticky", {31'b0, overrun}, 32'h1);

    // Flush together with a valid sample after 7 samples of 5.
    rdy = 1'b0;
    frame_const(12'h005, 7);
    flush = 1'b1;
    send(1'b1, 12'h009);
    flush = 1'b0;
    chk("flush_ovr", {31'b0, overrun}, 32'h0);
    frame_const(12'h001, 15);
    chk("flush_frame", {out_vld, out_data, frame_cnt}, {1'b1, 16'hFFF0, 8'd2});

    // Load and drain on the same edge.
    frame_const(12'h002, 14);
    rdy = 1'b1;
    send(1'b1, 12'h002);
    rdy = 1'b0;
    in_vld = 1'b0;
    chk("ld_drain", {out_vld, overrun, out_data, frame_cnt}, {1'b1, 1'b0, 16'hFFE1, 8'd3});

    // Asynchronous reset mid-frame with the slot full.
    frame_const(12'h00A, 5);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {out_vld, overrun, out_data, frame_cnt}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    frame_const(12'h003, 15);
    chk("post_reset", {out_vld, out_data, frame_cnt}, {1'b1, 16'hFFD2, 8'd1});

    // End-around carry on a 32-sample frame.
    for (int j = 0; j < 32; j++) begin
      in32_vld = 1'b1; in32_data = 12'hFFF;
      @(posedge clk); #1;
    end
    in32_vld = 1'b0;
    chk("carry32", {vld32, ovr32, data32, fc32}, {1'b1, 1'b0, 16'h001E, 8'd1});

    // Random traffic against a frame-sum model.
    do_reset();
    m_sum = 0; m_n = 0; m_vld = 0; m_ovr = 0; m_data = 0; m_fc = 0;
    for (int c = 0; c < 600; c++) begin
      in_vld  = ($urandom_range(9) < 7);
      in_data = 12'($urandom);
      rdy     = ($urandom_range(3) == 0);
      flush   = ($urandom_range(49) == 0);
      acc_s   = in_vld && !flush;
      m_done  = 1'b0;
      m_res   = 16'h0;
      if (flush) begin
        m_sum = 0; m_n = 0; m_ovr = 1'b0;
      end else if (acc_s) begin
        m_sum += int'(in_data);
        m_n++;
        if (m_n == 15) begin
          m_done = 1'b1;
          m_res  = ocsum(m_sum);
          m_sum  = 0;
          m_n    = 0;
        end
      end
      m_free = !m_vld || rdy;
      if (m_done && m_free) begin
        m_vld = 1'b1; m_data = m_res; m_fc = m_fc + 8'd1;
      end else begin
        if (m_done) m_ovr = 1'b1;
        if (m_vld && rdy) m_vld = 1'b0;
      end
      @(posedge clk); #1;
      chk("random", {out_vld, overrun, out_data, frame_cnt}, {m_vld, m_ovr, m_data, m_fc});
    end
    flush = 1'b0; in_vld = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
